// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0040_0000;
  localparam int unsigned     DEFAULT_TIMEOUT  = 16;

  // ERROR is only reachable when the fetch timeout is built in
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    ERROR = 2'd2
  } fetch_state_e;

  // Primary opcodes handy for building instruction words
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory handshake plus decoder-facing signals.
interface fetch_unit_if;
  import fetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] instr;
  logic            instr_valid;
  logic            dobranch;
  logic            dojump;
  logic            stall;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            fetch_err;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, fetch_err,
    input  imem_ack, imem_rdata, dobranch, dojump, stall
  );

  // Memory/decoder environment side
  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, fetch_err,
    output imem_ack, imem_rdata, dobranch, dojump, stall
  );

endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump beats branch beats sequential.
module next_pc_calc
  import fetch_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic            dobranch_i,
  input  logic            dojump_i,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [XLEN-1:0] next_pc_o
);

  logic [XLEN-1:0] br_off;

  assign pc_plus4_o = pc_i + 32'd4;
  assign br_off     = {{14{instr_i[15]}}, instr_i[15:0], 2'b00};

  // Jump keeps the current 256 MiB region; branch is pc+4 relative
  always_comb begin
    next_pc_o = pc_plus4_o;
    if (dojump_i) begin
      next_pc_o = {pc_plus4_o[31:28], instr_i[25:0], 2'b00};
    end else if (dobranch_i) begin
      next_pc_o = pc_plus4_o + br_off;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word per instruction
// over a req/ack handshake and holds it for the decoder until released.
// Optional macro FETCH_TIMEOUT_EN adds a sticky fetch timeout (ERROR state).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned     TIMEOUT  = DEFAULT_TIMEOUT
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  // A zero timeout would fault every fetch before it could be acked
  if (TIMEOUT == 0) begin : g_timeout_chk
    $error("fetch_unit: TIMEOUT must be at least 1");
  end

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            valid_q, valid_d;
  logic            imem_req_c;
  logic [XLEN-1:0] pc_plus4_c;
  logic [XLEN-1:0] next_pc_c;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  next_pc_calc u_next_pc (
    .pc_i       (pc_q),
    .instr_i    (instr_q),
    .dobranch_i (bus.dobranch),
    .dojump_i   (bus.dojump),
    .pc_plus4_o (pc_plus4_c),
    .next_pc_o  (next_pc_c)
  );

  // Next-state and request logic
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    imem_req_c = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
`endif
    case (state_q)
      FETCH: begin
        imem_req_c = 1'b1;
        if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          valid_d = 1'b1;
          state_d = ISSUE;
`ifdef FETCH_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ERROR;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      ISSUE: begin
        if (!bus.stall) begin
          pc_d    = next_pc_c;
          valid_d = 1'b0;
          state_d = FETCH;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ERROR: begin
        valid_d = 1'b0;
      end
      default: state_d = FETCH;
    endcase
    // No request may escape while the stage is being reset
    if (reset) imem_req_c = 1'b0;
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.imem_req    = imem_req_c;
  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4_c;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
`ifdef FETCH_TIMEOUT_EN
  assign bus.fetch_err   = err_q;
`else
  assign bus.fetch_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized instruction
// streams against a behavioural next-PC model.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic reset2;
  int   checks   = 0;
  int   failures = 0;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  fetch_unit_if bus ();
  fetch_unit_if bus2 ();

  fetch_unit #(.RESET_PC(32'h0040_0000), .TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(16)) dut_wrap (
    .clk   (clk),
    .reset (reset2),
    .bus   (bus2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural next PC from the instruction-set rules
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] ins,
                                           input logic br, input logic jp);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    if (jp) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    if (br) begin
      off = int'($signed(ins[15:0])) * 4;
      return seq + 32'(off);
    end
    return seq;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = $urandom;
    tick();
    tick();
    chk1("rst_req", bus.imem_req, 1'b0);
    chk("rst_pc", bus.pc, 32'h0040_0000);
    chk("rst_instr", bus.instr, 32'h0);
    chk1("rst_valid", bus.instr_valid, 1'b0);
    chk1("rst_err", bus.fetch_err, 1'b0);
    reset = 1'b0;
    bus.imem_ack = 1'b0;
    #1;
    chk1("post_rst_req", bus.imem_req, 1'b1);
    exp_pc = 32'h0040_0000;
  endtask

  // One instruction: lat wait states, stl stall cycles, then release
  task automatic run_instr(input logic [31:0] word, input int lat, input int stl,
                           input logic br, input logic jp);
    for (int i = 0; i < lat; i++) begin
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = $urandom;
      bus.dobranch   = 1'($urandom);
      bus.dojump     = 1'($urandom);
      bus.stall      = 1'($urandom);
      #1;
      chk1("wait_req", bus.imem_req, 1'b1);
      chk("wait_addr", bus.imem_addr, exp_pc);
      chk1("wait_valid", bus.instr_valid, 1'b0);
      chk1("wait_err", bus.fetch_err, 1'b0);
      tick();
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    #1;
    chk1("ack_req", bus.imem_req, 1'b1);
    chk("ack_addr", bus.imem_addr, exp_pc);
    chk1("ack_valid", bus.instr_valid, 1'b0);
    tick();
    for (int i = 0; i < stl; i++) begin
      bus.stall      = 1'b1;
      bus.imem_ack   = 1'($urandom);
      bus.imem_rdata = $urandom;
      bus.dobranch   = 1'($urandom);
      bus.dojump     = 1'($urandom);
      #1;
      chk1("stall_valid", bus.instr_valid, 1'b1);
      chk("stall_instr", bus.instr, word);
      chk("stall_pc", bus.pc, exp_pc);
      chk1("stall_req", bus.imem_req, 1'b0);
      tick();
    end
    bus.stall      = 1'b0;
    bus.imem_ack   = 1'($urandom);
    bus.imem_rdata = $urandom;
    bus.dobranch   = br;
    bus.dojump     = jp;
    #1;
    chk1("issue_valid", bus.instr_valid, 1'b1);
    chk("issue_instr", bus.instr, word);
    chk("issue_pc", bus.pc, exp_pc);
    chk("issue_pc4", bus.pc_plus4, exp_pc + 32'd4);
    chk1("issue_req", bus.imem_req, 1'b0);
    chk("pc_align", {30'b0, bus.pc[1:0]}, 32'h0);
    tick();
    exp_pc = ref_next(exp_pc, word, br, jp);
    bus.imem_ack = 1'b0;
    bus.dobranch = 1'b0;
    bus.dojump   = 1'b0;
    #1;
    chk1("next_valid", bus.instr_valid, 1'b0);
    chk("next_addr", bus.imem_addr, exp_pc);
  endtask

  initial begin
    logic [31:0] w;
    logic [5:0]  op;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.dobranch = 1'b0;
    bus.dojump = 1'b0; bus.stall = 1'b0;
    bus2.imem_ack = 1'b0; bus2.imem_rdata = '0; bus2.dobranch = 1'b0;
    bus2.dojump = 1'b0; bus2.stall = 1'b0;
    reset2 = 1'b1;
    reset  = 1'b1;

    // Zero-wait sequential fetches
    do_reset();
    run_instr({OP_ADDIU, 26'h0210005}, 0, 0, 1'b0, 1'b0);
    chk("seq_addr1", bus.imem_addr, 32'h0040_0004);
    run_instr({OP_ADDIU, 26'h0210006}, 0, 0, 1'b0, 1'b0);
    chk("seq_addr2", bus.imem_addr, 32'h0040_0008);
    run_instr({OP_ADDIU, 26'h0210007}, 0, 0, 1'b0, 1'b0);

    // Three wait states
    run_instr({OP_ADDIU, 26'h0210008}, 3, 0, 1'b0, 1'b0);
    chk("wait_next", bus.imem_addr, 32'h0040_0010);

    // Branches: offset -1 and +3, then jump with both flags set
    run_instr(32'h1000_FFFF, 0, 0, 1'b1, 1'b0);
    chk("br_back", bus.imem_addr, 32'h0040_0010);
    run_instr(32'h1400_0003, 1, 0, 1'b1, 1'b0);
    chk("br_fwd", bus.imem_addr, 32'h0040_0020);
    run_instr(32'h0810_0040, 0, 0, 1'b1, 1'b1);
    chk("jump_prio", bus.imem_addr, 32'h0040_0100);

    // Five stall cycles with spurious acks
    run_instr({OP_ADDIU, 26'h0000001}, 0, 5, 1'b0, 1'b0);
    chk("stall_next", bus.imem_addr, 32'h0040_0104);

    // Randomized instruction stream
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       op = OP_J;
        1:       op = OP_BEQ;
        2:       op = OP_BNE;
        default: op = OP_ADDIU;
      endcase
      w = {op, 26'($urandom)};
      run_instr(w, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom));
    end

    // Longest wait that still completes when a timeout is built in
    run_instr({OP_ADDIU, 26'h0000002}, 15, 0, 1'b0, 1'b0);
`ifndef FETCH_TIMEOUT_EN
    run_instr({OP_ADDIU, 26'h0000003}, 30, 0, 1'b0, 1'b0);
`endif

    // Reset during FETCH with an ack discards it
    reset = 1'b1;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("mid_rst_pc", bus.pc, 32'h0040_0000);
    chk1("mid_rst_valid", bus.instr_valid, 1'b0);
    chk("mid_rst_instr", bus.instr, 32'h0);
    chk1("mid_rst_req", bus.imem_req, 1'b0);
    reset = 1'b0;
    bus.imem_ack = 1'b0;
    exp_pc = 32'h0040_0000;
    #1;
    chk1("mid_rst_req1", bus.imem_req, 1'b1);
    run_instr({OP_ADDIU, 26'h0000004}, 1, 0, 1'b0, 1'b0);

`ifdef FETCH_TIMEOUT_EN
    // No ack: error after the 16th FETCH cycle, sticky until reset
    bus.imem_ack = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k < 16) begin
        chk1("to_req", bus.imem_req, 1'b1);
        chk1("to_err_low", bus.fetch_err, 1'b0);
      end else begin
        chk1("to_err", bus.fetch_err, 1'b1);
        chk1("to_req_off", bus.imem_req, 1'b0);
        chk1("to_valid", bus.instr_valid, 1'b0);
      end
    end
    for (int k = 0; k < 4; k++) begin
      bus.imem_ack = 1'b1;
      tick();
      chk1("to_sticky", bus.fetch_err, 1'b1);
      chk1("to_sticky_req", bus.imem_req, 1'b0);
    end
    bus.imem_ack = 1'b0;
    do_reset();
    chk1("to_cleared", bus.fetch_err, 1'b0);
`endif

    // Address wrap on the second instance
    tick();
    chk("wrap_rst_pc", bus2.pc, 32'hFFFF_FFFC);
    reset2 = 1'b0;
    #1;
    chk("wrap_pc4", bus2.pc_plus4, 32'h0000_0000);
    chk1("wrap_req", bus2.imem_req, 1'b1);
    bus2.imem_ack   = 1'b1;
    bus2.imem_rdata = {OP_ADDIU, 26'h0000009};
    tick();
    bus2.imem_ack = 1'b0;
    bus2.stall    = 1'b0;
    #1;
    chk1("wrap_valid", bus2.instr_valid, 1'b1);
    tick();
    chk("wrap_addr", bus2.imem_addr, 32'h0000_0000);
    chk1("wrap_req2", bus2.imem_req, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
